// File: rtl/fp_mul_param.sv
// fp_mul_param: multi-cycle IEEE-754 multiplier, RNE rounding, bit-serial mantissa product.
// Define FP_MUL_DENORM_EN to handle subnormal operands/results; otherwise they flush to zero.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 nan_o,
  output logic                 infinit_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 inexact_o
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 1;
  localparam int P = 2 * M;
  localparam int XW = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam int CW = $clog2(M);

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, prod_q, prod_d;
  logic [P-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [M-1:0]   mplier_q, mplier_d, man_q, man_d;
  logic [2:0]     grs_q, grs_d;
  logic [XW-1:0]  exp_q, exp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d;
  logic [4:0]     flg_q, flg_d;
  logic           done_q, done_d, busy_q, busy_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [M-1:0]     ma, mb;
  logic [XW-1:0]    ae, be, esum;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sab, is_nan, is_inf, is_zero;

  // classify operands, form hidden-bit significands and the rebiased exponent sum
  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    a_inf = &ea && fa == '0;
    b_inf = &eb && fb == '0;
    a_nan = &ea && fa != '0;
    b_nan = &eb && fb != '0;
`ifdef FP_MUL_DENORM_EN
    a_zero = ea == '0 && fa == '0;
    b_zero = eb == '0 && fb == '0;
    ma = {|ea, fa};
    mb = {|eb, fb};
`else
    a_zero = ea == '0;
    b_zero = eb == '0;
    ma = {1'b1, fa};
    mb = {1'b1, fb};
`endif
    ae = {2'b00, ea == '0 ? EXP_W'(1) : ea};
    be = {2'b00, eb == '0 ? EXP_W'(1) : eb};
    esum = ae + be - XW'(BIAS);
    sab = a_q[W-1] ^ b_q[W-1];
    is_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    is_inf = a_inf | b_inf;
    is_zero = a_zero | b_zero;
  end

  logic [P-1:0]  nv;
  logic [XW-1:0] ne;
`ifdef FP_MUL_DENORM_EN
  int lz, sh;
`endif

  // normalise the raw product so the hidden bit sits at the top; subnormal products stop at exponent 1
  always_comb begin
`ifdef FP_MUL_DENORM_EN
    lz = 0;
    for (int i = 0; i < P - 1; i++) if (acc_q[i]) lz = P - 2 - i;
    sh = (exp_q[XW-1] || exp_q <= XW'(1)) ? 0 : (lz < int'(exp_q) - 1 ? lz : int'(exp_q) - 1);
    nv = acc_q[P-1] ? acc_q : acc_q << (sh + 1);
    ne = acc_q[P-1] ? exp_q + XW'(1) : exp_q - XW'(sh);
`else
    nv = acc_q[P-1] ? acc_q : acc_q << 1;
    ne = acc_q[P-1] ? exp_q + XW'(1) : exp_q;
`endif
  end

  logic [M+1:0]  mx;
  logic [M:0]    rs;
  logic [M-1:0]  rm, fm;
  logic [XW-1:0] ee, fe;
  logic          st, up, carry, ix, tiny, exp_le0, fe_le0, fe_ovf;
`ifdef FP_MUL_DENORM_EN
  logic [2*M+3:0] wide;
  int dsh;
`endif

  // denormalise tiny results, then round to nearest even with carry renormalisation
  always_comb begin
    exp_le0 = exp_q[XW-1] | ~|exp_q;
`ifdef FP_MUL_DENORM_EN
    dsh = exp_le0 ? int'(XW'(1) - exp_q) : 0;
    dsh = dsh > M + 2 ? M + 2 : dsh;
    wide = {man_q, grs_q[2:1], {(M+2){1'b0}}} >> dsh;
    mx = wide[2*M+3:M+2];
    st = grs_q[0] | |wide[M+1:0];
    ee = exp_le0 ? XW'(1) : exp_q;
    tiny = ~mx[M+1];
`else
    mx = {man_q, grs_q[2:1]};
    st = grs_q[0];
    ee = exp_q;
    tiny = 1'b0;
`endif
    rm = mx[M+1:2];
    ix = mx[1] | mx[0] | st;
    up = mx[1] & (mx[0] | st | rm[0]);
    rs = {1'b0, rm} + (M+1)'(up);
    carry = rs[M];
    fm = carry ? rs[M:1] : rs[M-1:0];
    fe = ee + XW'(carry);
    fe_le0 = fe[XW-1] | ~|fe;
    fe_ovf = ~fe[XW-1] & (fe[XW-2:0] >= (XW-1)'(EMAX));
  end

  // sequencing, serial multiply and result/flag selection
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    prod_d = prod_q;
    mcand_d = mcand_q;
    acc_d = acc_q;
    mplier_d = mplier_q;
    man_d = man_q;
    grs_d = grs_q;
    exp_d = exp_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    flg_d = flg_q;
    case (state_q)
      IDLE: if (start_i) begin
        a_d = a_i;
        b_d = b_i;
        state_d = UNPACK;
      end
      UNPACK: begin
        sgn_d = sab;
        mcand_d = {{M{1'b0}}, ma};
        mplier_d = mb;
        acc_d = '0;
        cnt_d = '0;
        exp_d = esum;
        state_d = (is_nan | is_inf | is_zero) ? DONE : MULT;
        prod_d = is_nan ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
               : is_inf ? {sab, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : is_zero ? {sab, {(W-1){1'b0}}} : prod_q;
        flg_d = is_nan ? 5'b10000 : is_inf ? 5'b01000 : is_zero ? 5'b00000 : flg_q;
      end
      MULT: begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(M - 1) ? NORM : MULT;
      end
      NORM: begin
        man_d = nv[P-1 -: M];
        grs_d = {nv[P-M-1], nv[P-M-2], |nv[P-M-3:0]};
        exp_d = ne;
        state_d = ROUND;
      end
      ROUND: begin
        prod_d = fe_ovf ? {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : fe_le0 ? {sgn_q, {(W-1){1'b0}}}
               : {sgn_q, fm[M-1] ? fe[EXP_W-1:0] : EXP_W'(0), fm[M-2:0]};
        flg_d = fe_ovf ? 5'b00101 : fe_le0 ? 5'b00011 : {3'b000, tiny & ix, ix};
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end

  // state and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      mcand_q <= '0;
      acc_q <= '0;
      mplier_q <= '0;
      man_q <= '0;
      grs_q <= '0;
      exp_q <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
      flg_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      prod_q <= prod_d;
      mcand_q <= mcand_d;
      acc_q <= acc_d;
      mplier_q <= mplier_d;
      man_q <= man_d;
      grs_q <= grs_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      flg_q <= flg_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign product_o = prod_q;
  assign {nan_o, infinit_o, overflow_o, underflow_o, inexact_o} = flg_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_fp_mul_param.sv
// tb_fp_mul_param: directed FP32 vectors for fp_mul_param with hand-computed results
module tb_fp_mul_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [31:0] product_o;
  logic        done_o, busy_o, nan_o, infinit_o, overflow_o, underflow_o, inexact_o;
  logic [4:0]  flg;
  int          n_pass = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  assign flg = {nan_o, infinit_o, overflow_o, underflow_o, inexact_o};

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .product_o(product_o), .done_o(done_o), .busy_o(busy_o), .nan_o(nan_o),
    .infinit_o(infinit_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .inexact_o(inexact_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // lat = cycle index of done_o (accepting edge is cycle 0); 100 means no done seen
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int pulse_at, input int rst_at, output int lat);
    @(negedge clk);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      start_i = lat == pulse_at;
      if (lat == pulse_at) begin
        a_i = 32'h3F800000;
        b_i = 32'h3F800000;
      end
      rst = lat == rst_at;
      if (rst) begin
        #1;
        check("reset mid-op product", product_o, 0);
        check("reset mid-op flags", flg, 0);
        check("reset mid-op busy", busy_o, 0);
        check("reset mid-op done", done_o, 0);
      end
      if (done_o) break;
      @(posedge clk);
      lat++;
    end
    start_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic tcase(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ep, input logic [4:0] ef, input int el);
    int lat;
    op(a, b, 0, 0, lat);
    check({tag, " latency"}, lat, el);
    check({tag, " product"}, product_o, ep);
    check({tag, " flags"}, flg, ef);
    check({tag, " busy in done"}, busy_o, 1);
    @(negedge clk);
    check({tag, " busy after"}, busy_o, 0);
    check({tag, " done after"}, done_o, 0);
  endtask

  initial begin
    int lat;
    #2 rst = 1'b1;
    #1;
    check("reset product", product_o, 0);
    check("reset flags", flg, 0);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tcase("3*2.5", 32'h40400000, 32'h40200000, 32'h40F00000, 5'b00000, 28);
    tcase("qnan*1", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 2);
    tcase("inf*-0", 32'h7F800000, 32'h80000000, 32'h7FC00000, 5'b10000, 2);
    tcase("overflow", 32'h7F000000, 32'h40000000, 32'h7F800000, 5'b00101, 28);
    tcase("neg overflow", 32'hFF000000, 32'h40000000, 32'hFF800000, 5'b00101, 28);
    tcase("-inf*2", 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000, 2);
    tcase("inf*-inf", 32'h7F800000, 32'hFF800000, 32'hFF800000, 5'b01000, 2);
    tcase("-0*2", 32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2);
    tcase("inexact", 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 28);
    tcase("tie odd up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00001, 28);
    tcase("tie even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'b00001, 28);
`ifdef FP_MUL_DENORM_EN
    tcase("tiny exact", 32'h00800000, 32'h3F000000, 32'h00400000, 5'b00000, 28);
    tcase("sub*1", 32'h00000001, 32'h3F800000, 32'h00000001, 5'b00000, 28);
    tcase("sub*sub", 32'h00000001, 32'h00000001, 32'h00000000, 5'b00011, 28);
`else
    tcase("tiny flush", 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 28);
    tcase("sub*1", 32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2);
    tcase("sub*sub", 32'h00000001, 32'h00000001, 32'h00000000, 5'b00000, 2);
`endif
    op(32'h40400000, 32'h40200000, 10, 0, lat);
    check("ignored start latency", lat, 28);
    check("ignored start product", product_o, 32'h40F00000);
    check("ignored start flags", flg, 0);
    op(32'h7F000000, 32'h40000000, 0, 15, lat);
    check("abort no done", lat, 100);
    check("abort product held zero", product_o, 0);
    tcase("after reset", 32'h40400000, 32'h40200000, 32'h40F00000, 5'b00000, 28);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
